seq_serializer: RTL and testbench

//  Upstream stage of the serial sequence detector: accepts a parallel word over a

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_gap_counter.sv | 30 +++
 rtl/seq_serializer.sv | 117 +++++++++++
 tb/tb_seq_serializer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and its detector bench: FSM encodings and load length clamp.
// Purely declarative; no timing or flow control of its own.
package seq_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] SHIFT_ENC = 2'd1;
  localparam logic [1:0] GAP_ENC   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    SHIFT = SHIFT_ENC,
    GAP   = GAP_ENC
  } seq_state_e;

  // A zero length, or one longer than the word, means "send the whole word".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/seq_gap_counter.sv
// Loadable saturating down-counter that times the idle gap between words; zero flag is combinational from the count.
// Load takes effect on the next edge; no backpressure.
module seq_gap_counter #(
  parameter int COUNT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(COUNT + 1);

  logic [CW-1:0] cnt_q;

  // Loaded with COUNT-1 so the owner spends exactly COUNT cycles in its gap state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(COUNT - 1);
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial word shifter, MSB-first, feeding the sequence detector; first bit one cycle after accept.
// load_ready low while shifting or gapping (high on the last bit when there is no gap); offers are not queued.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;
  logic             last_bit;
  logic             accept;
  logic             gap_load;
  logic             gap_zero;

  assign eff_len  = LEN_W'(clamp_len(32'(load_len), WIDTH));
  // Left-align the word so its first bit always sits in the MSB of the shifter.
  assign aligned  = load_data << (LEN_W'(WIDTH) - eff_len);
  assign last_bit = (state_q == SHIFT) && (idx_q == len_q - LEN_W'(1));

  assign load_ready = (state_q == IDLE) || ((GAP_CYCLES == 0) && last_bit);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    gap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          if (accept) begin
            state_d = SHIFT;
          end else if (GAP_CYCLES > 0) begin
            state_d  = GAP;
            gap_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      sequence_out <= 1'b0;
      bit_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= last_bit;
      if (accept) begin
        shreg_q      <= aligned << 1;
        len_q        <= eff_len;
        idx_q        <= '0;
        sequence_out <= aligned[WIDTH-1];
        bit_valid    <= 1'b1;
      end else if (state_q == SHIFT && !last_bit) begin
        shreg_q      <= shreg_q << 1;
        idx_q        <= idx_q + LEN_W'(1);
        sequence_out <= shreg_q[WIDTH-1];
        bit_valid    <= 1'b1;
      end else begin
        sequence_out <= 1'b0;
        bit_valid    <= 1'b0;
      end
    end
  end

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      seq_gap_counter #(
        .COUNT (GAP_CYCLES)
      ) u_gap (
        .clock (clock),
        .reset (reset),
        .load  (gap_load),
        .dec   (state_q == GAP),
        .zero  (gap_zero)
      );
    end else begin : g_nogap
      logic unused_gap_load;
      assign unused_gap_load = gap_load;
      assign gap_zero        = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: one instance without a gap, one with a 3-cycle gap.
// Checks every numbered test of the spec cycle by cycle; a watchdog bounds total run time.
// Stimulus holds load_valid until the accept edge; no random backpressure.
module tb_seq_serializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       load_valid, load_ready, sequence_out, bit_valid, busy, done;
    logic [7:0] load_data;
    logic [3:0] load_len;

    logic       lv3, lr3, so3, bv3, busy3, done3;
    logic [7:0] ld3;
    logic [3:0] ll3;

    int tests = 0;
    int fails = 0;

    seq_serializer #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(0)) dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_len     (load_len),
        .sequence_out (sequence_out),
        .bit_valid    (bit_valid),
        .busy         (busy),
        .done         (done)
    );

    seq_serializer #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(3)) dut_gap (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (lv3),
        .load_ready   (lr3),
        .load_data    (ld3),
        .load_len     (ll3),
        .sequence_out (so3),
        .bit_valid    (bv3),
        .busy         (busy3),
        .done         (done3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        fails++;
        $error("FAIL watchdog: wait expired before the bench finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [15:0] exp_bits;
        logic [3:0]  lens [2];
        int          ones, dones;

        reset = 1'b0; load_valid = 1'b0; load_data = '0; load_len = '0;
        lv3 = 1'b0; ld3 = '0; ll3 = '0;

        // 1. reset held three cycles
        repeat (3) tick();
        check("rst_seq_out", sequence_out, 1'b0);
        check("rst_bit_valid", bit_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b1;
        tick();
        check("rst_ready", load_ready, 1'b1);

        // 2. 8'h0B, len 4 -> 1,0,1,1 then done
        load_valid = 1'b1; load_data = 8'h0B; load_len = 4'd4;
        tick();
        load_valid = 1'b0; load_data = 8'h00;
        check("w0b_b1", sequence_out, 1'b1);
        check("w0b_v1", bit_valid, 1'b1);
        check("w0b_busy", busy, 1'b1);
        tick();
        check("w0b_b2", sequence_out, 1'b0);
        check("w0b_v2", bit_valid, 1'b1);
        check("w0b_ready_mid", load_ready, 1'b0);
        tick();
        check("w0b_b3", sequence_out, 1'b1);
        tick();
        check("w0b_b4", sequence_out, 1'b1);
        check("w0b_done4", done, 1'b0);
        tick();
        check("w0b_done5", done, 1'b1);
        check("w0b_v5", bit_valid, 1'b0);
        check("w0b_idle", busy, 1'b0);
        tick();
        check("w0b_done_pulse", done, 1'b0);

        // 3. back-to-back A5 then 3C, no bubble
        exp_bits = 16'hA53C;
        load_valid = 1'b1; load_data = 8'hA5; load_len = 4'd8;
        tick();
        load_data = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            check("b2b_bit", sequence_out, exp_bits[15-i]);
            check("b2b_valid", bit_valid, 1'b1);
            check("b2b_done", done, (i == 8));
            if (i == 7) check("b2b_ready_last", load_ready, 1'b1);
            if (i == 8) load_valid = 1'b0;
            tick();
        end
        check("b2b_done_end", done, 1'b1);
        check("b2b_valid_end", bit_valid, 1'b0);

        // 4. len 0 and len 15 clamp to a full byte
        lens[0] = 4'd0; lens[1] = 4'd15;
        for (int k = 0; k < 2; k++) begin
            tick();
            load_valid = 1'b1; load_data = 8'hFF; load_len = lens[k];
            ones = 0; dones = 0;
            tick();
            load_valid = 1'b0;
            for (int c = 0; c < 12; c++) begin
                if (sequence_out && bit_valid) ones++;
                if (done) dones++;
                tick();
            end
            check("clamp_ones", ones, 8);
            check("clamp_dones", dones, 1);
        end

        // 5. gap instance, len 2 word 2'b11 then 3 gap cycles
        lv3 = 1'b1; ld3 = 8'h03; ll3 = 4'd2;
        check("gap_ready_idle", lr3, 1'b1);
        tick();
        lv3 = 1'b0;
        check("gap_b1", so3, 1'b1);
        check("gap_v1", bv3, 1'b1);
        tick();
        check("gap_b2", so3, 1'b1);
        check("gap_ready_last", lr3, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick();
            check("gap_ready", lr3, 1'b0);
            check("gap_seq_out", so3, 1'b0);
            check("gap_valid", bv3, 1'b0);
            check("gap_busy", busy3, 1'b1);
            check("gap_done", done3, (g == 0));
        end
        tick();
        check("gap_ready_after", lr3, 1'b1);
        check("gap_busy_after", busy3, 1'b0);

        // 6. reset after the 2nd bit of 8'hFF aborts the word
        load_valid = 1'b1; load_data = 8'hFF; load_len = 4'd8;
        tick();
        load_valid = 1'b0;
        check("abort_b1", sequence_out, 1'b1);
        tick();
        check("abort_b2", sequence_out, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_seq_out", sequence_out, 1'b0);
        check("abort_valid", bit_valid, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_busy", busy, 1'b0);
        tick();
        check("abort_no_done", done, 1'b0);
        check("abort_ready", load_ready, 1'b1);
        exp_bits = 16'h000B;
        load_valid = 1'b1; load_data = 8'h0B; load_len = 4'd4;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("post_bit", sequence_out, exp_bits[3-i]);
            check("post_valid", bit_valid, 1'b1);
            tick();
        end
        check("post_done", done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
